mem_stage_access: RTL and testbench

- Memory-stage consumer of the 4-bit M control bundle emitted by the instruction decoder. M is {MemRead[1:0], MemWrite[1:0]}, with code 2'b01 = word and 2'b10 = byte.
- Turns a decoded load/store into a req/ack transaction on the data-memory port.
- Performs big-endian byte-lane steering and sign-extends lb results.
- Stalls the pipeline while a transaction is outstanding.

---
 rtl/mem_stage_access.sv | 155 +++++++++++++++
 tb/tb_mem_stage_access.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_access.sv
// Memory-stage load/store sequencer: req/ack handshake with timeout,
// big-endian byte-lane steering and lb sign extension.
module mem_stage_access #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [3:0]        M,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              align_err,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              align_err_q, bus_err_q;
    logic              mem_we_q;
    logic [3:0]        mem_be_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       rdata_q;
    logic              word_q;
    logic [1:0]        off_q;

    logic [1:0]        mem_read, mem_write, off;
    logic              illegal, is_word, misalign;
    logic              err_pulse, start, go;
    logic              ack_hit, timeout_hit;
    logic [3:0]        be_steer;
    logic [31:0]       wdata_steer;
    logic [7:0]        ld_byte;
    logic [31:0]       ld_fmt;

    // Start/decode. An error pulse cycle never re-accepts: the faulting
    // instruction is still on the inputs while upstream advances past it.
    always_comb begin
        mem_read    = M[3:2];
        mem_write   = M[1:0];
        off         = addr[1:0];
        illegal     = (mem_read == 2'b11) || (mem_write == 2'b11) ||
                      ((mem_read != 2'b00) && (mem_write != 2'b00));
        is_word     = (mem_read == 2'b01) || (mem_write == 2'b01);
        misalign    = !illegal && is_word && (off != 2'b00);
        err_pulse   = align_err_q || bus_err_q;
        start       = valid_in && (state_q == S_IDLE) && (M != 4'b0000) && !err_pulse;
        go          = start && !illegal && !misalign;
        ack_hit     = (state_q == S_ACCESS) && mem_ack;
        timeout_hit = (state_q == S_ACCESS) && !mem_ack && (cnt_q == TO_LAST);
    end

    always_comb begin
        be_steer    = is_word ? 4'b1111 : (4'b1000 >> off);
        wdata_steer = is_word ? wdata : {4{wdata[7:0]}};
        case (off_q)
            2'd0:    ld_byte = mem_rdata[31:24];
            2'd1:    ld_byte = mem_rdata[23:16];
            2'd2:    ld_byte = mem_rdata[15:8];
            default: ld_byte = mem_rdata[7:0];
        endcase
        ld_fmt = word_q ? mem_rdata : {{24{ld_byte[7]}}, ld_byte};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (go) state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            align_err_q <= 1'b0;
            bus_err_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            word_q      <= 1'b0;
            off_q       <= '0;
        end else begin
            align_err_q <= start && misalign;
            bus_err_q   <= (start && illegal) || timeout_hit;
            if (go) begin
                mem_we_q    <= (mem_write != 2'b00);
                mem_be_q    <= be_steer;
                mem_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                mem_wdata_q <= wdata_steer;
                word_q      <= is_word;
                off_q       <= off;
            end
            if (ack_hit && !mem_we_q) rdata_q <= ld_fmt;
        end
    end

    always_comb begin
        stall     = (state_q == S_ACCESS) || start;
        mem_req   = (state_q == S_ACCESS);
        done      = (state_q == S_RESP);
        align_err = align_err_q;
        bus_err   = bus_err_q;
        mem_we    = mem_we_q;
        mem_be    = mem_be_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        rdata     = rdata_q;
    end

endmodule

// File: tb/tb_mem_stage_access.sv
// Bench for mem_stage_access: directed scenarios plus randomized
// transactions against a transaction-level reference model.
module tb_mem_stage_access;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [3:0]  M;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall, done, align_err, bus_err, mem_req, mem_we;
    logic [31:0] rdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] exp_rdata = '0;

    mem_stage_access #(.TIMEOUT(TO), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .M(M), .addr(addr),
        .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
        .align_err(align_err), .bus_err(bus_err), .mem_req(mem_req),
        .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_aerr"},  32'(align_err), 32'd0);
        check({tag, "_berr"},  32'(bus_err), 32'd0);
        check({tag, "_req"},   32'(mem_req), 32'd0);
        check({tag, "_we"},    32'(mem_we), 32'd0);
        check({tag, "_be"},    32'(mem_be), 32'd0);
        check({tag, "_addr"},  mem_addr, 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
    endtask

    // One instruction presented from IDLE; ack_after = index of the ACCESS
    // cycle carrying mem_ack (>= TO means no ack -> timeout).
    task automatic txn(input logic [3:0] m, input logic [31:0] a, input logic [31:0] wd,
                       input int ack_after, input logic [31:0] rdm);
        logic [1:0]  rdv, wrv, off;
        bit          illegal, word, mis, acked;
        logic [31:0] e_addr, e_wd, byte_v;
        logic [3:0]  e_be;
        rdv     = m[3:2];
        wrv     = m[1:0];
        off     = a[1:0];
        illegal = (rdv == 2'd3) || (wrv == 2'd3) || (rdv != 0 && wrv != 0);
        word    = (rdv == 2'd1) || (wrv == 2'd1);
        mis     = !illegal && word && off != 0;
        e_addr  = a - 32'(off);
        e_be    = word ? 4'hF : 4'(1 << (3 - int'(off)));
        e_wd    = word ? wd : 32'(wd[7:0]) * 32'h01010101;
        acked   = 0;

        valid_in = 1'b1; M = m; addr = a; wdata = wd; mem_ack = 1'b0;
        #1;
        check("stall_start", 32'(stall), 32'(m != 0));
        if (m == 4'b0000) begin
            tick();
            check("pass_done", 32'(done), 32'd0);
            check("pass_req", 32'(mem_req), 32'd0);
            valid_in = 1'b0;
            return;
        end
        if (illegal || mis) begin
            tick();
            check("err_bus", 32'(bus_err), 32'(illegal));
            check("err_align", 32'(align_err), 32'(mis));
            check("err_req", 32'(mem_req), 32'd0);
            check("err_stall", 32'(stall), 32'd0);
            check("err_done", 32'(done), 32'd0);
            valid_in = 1'b0; M = 4'b0000;
            tick();
            check("err_clear", 32'({bus_err, align_err, mem_req, done}), 32'd0);
            check("err_rdata", rdata, exp_rdata);
            return;
        end
        for (int k = 0; k < TO; k++) begin
            tick();
            check("acc_req", 32'(mem_req), 32'd1);
            check("acc_stall", 32'(stall), 32'd1);
            check("acc_done", 32'(done), 32'd0);
            check("acc_addr", mem_addr, e_addr);
            check("acc_we", 32'(mem_we), 32'(wrv != 0));
            check("acc_be", 32'(mem_be), 32'(e_be));
            if (wrv != 0) check("acc_wdata", mem_wdata, e_wd);
            if (k == ack_after) begin
                mem_ack = 1'b1; mem_rdata = rdm; acked = 1;
                break;
            end
        end
        tick();
        mem_ack = 1'b0; mem_rdata = $urandom;
        if (acked) begin
            if (rdv != 0) begin
                byte_v    = (rdm >> (8 * (3 - int'(off)))) & 32'hFF;
                exp_rdata = word ? rdm : (byte_v >= 32'h80 ? byte_v + 32'hFFFFFF00 : byte_v);
            end
            check("resp_done", 32'(done), 32'd1);
            check("resp_req", 32'(mem_req), 32'd0);
            check("resp_stall", 32'(stall), 32'd0);
            check("resp_berr", 32'(bus_err), 32'd0);
            check("resp_rdata", rdata, exp_rdata);
        end else begin
            check("to_berr", 32'(bus_err), 32'd1);
            check("to_req", 32'(mem_req), 32'd0);
            check("to_done", 32'(done), 32'd0);
            check("to_stall", 32'(stall), 32'd0);
        end
        valid_in = 1'b0; M = 4'b0000;
        tick();
        check("post_done", 32'(done), 32'd0);
        check("post_berr", 32'(bus_err), 32'd0);
        check("post_rdata", rdata, exp_rdata);
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            valid_in  = 1'b0;
            mem_ack   = 1'($urandom);
            mem_rdata = $urandom;
            tick();
            check("gap_done", 32'(done), 32'd0);
            check("gap_req", 32'(mem_req), 32'd0);
            check("gap_rdata", rdata, exp_rdata);
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        logic [3:0] mlist [6];
        logic [3:0] mm;
        mlist = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0000, 4'b0101};
        rst = 1'b1; valid_in = 1'b0; M = '0; addr = '0; wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        txn(4'b0100, 32'h0000_0104, 32'h0, 0, 32'hDEADBEEF);
        txn(4'b0010, 32'h0000_020A, 32'h1234_56AB, 3, 32'h0);
        txn(4'b1000, 32'h0000_0301, 32'h0, 0, 32'h1180FF22);
        txn(4'b1000, 32'h0000_0303, 32'h0, 1, 32'h1180FF22);
        txn(4'b0100, 32'h0000_0102, 32'h0, 0, 32'h0);
        txn(4'b0001, 32'h0000_0108, 32'hCAFE_F00D, 1, 32'h0);
        txn(4'b0001, 32'h0000_0010, 32'h0000_0055, 99, 32'h0);
        txn(4'b0101, 32'h0000_0010, 32'h0, 0, 32'h0);
        txn(4'b1100, 32'h0000_0010, 32'h0, 0, 32'h0);
        txn(4'b0011, 32'h0000_0010, 32'h0, 0, 32'h0);
        txn(4'b0000, 32'h0000_0010, 32'h0, 0, 32'h0);

        // reset in the 2nd ACCESS cycle of an lw, then a late ack
        valid_in = 1'b1; M = 4'b0100; addr = 32'h0000_0400;
        #1;
        check("rst_stall0", 32'(stall), 32'd1);
        tick();
        check("rst_req1", 32'(mem_req), 32'd1);
        tick();
        check("rst_req2", 32'(mem_req), 32'd1);
        rst = 1'b1; valid_in = 1'b0; M = 4'b0000;
        tick();
        exp_rdata = '0;
        check_all_zero("midrst");
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        check("late_done", 32'(done), 32'd0);
        check("late_rdata", rdata, 32'd0);
        mem_ack = 1'b0;
        tick();
        check("late_done2", 32'(done), 32'd0);
        check("late_rdata2", rdata, 32'd0);

        for (int t = 0; t < 120; t++) begin
            mm = ($urandom_range(0, 7) == 0) ? 4'($urandom) : mlist[$urandom_range(0, 5)];
            txn(mm, $urandom, $urandom, $urandom_range(0, 5), $urandom);
            idle_gap($urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
